// File: rtl/serial_comparator_pkg.sv
// serial_cmp_pkg: shared definitions for the bit-serial magnitude comparator.
//   - 2-bit result codes driven on sout
//   - FSM state encoding used by serial_comparator
package serial_cmp_pkg;

  // Result codes
  localparam logic [1:0] CMP_NA = 2'b00;  // no result / not available
  localparam logic [1:0] CMP_LT = 2'b01;  // A < B
  localparam logic [1:0] CMP_EQ = 2'b10;  // A == B
  localparam logic [1:0] CMP_GT = 2'b11;  // A > B

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OP   = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Code for one differing bit pair; inv flips the sense (two's-complement
  // sign position, where a set bit means the smaller value).
  function automatic logic [1:0] pair_code(input logic ai, input logic bi,
                                           input logic inv);
    return ((ai & ~bi) ^ inv) ? CMP_GT : CMP_LT;
  endfunction

endpackage

// File: rtl/serial_comparator_if.sv
// serial_cmp_if: handshake/operand bundle for serial_comparator.
//   master : drives start, bit_vld, ai, bi (and signed_mode when
//            SERIAL_CMP_SIGNED_EN is defined); observes busy, done, sout
//   slave  : the comparator side
// Optional macro: SERIAL_CMP_SIGNED_EN adds signed_mode.
interface serial_cmp_if;
  logic       start;
  logic       bit_vld;
  logic       ai;
  logic       bi;
`ifdef SERIAL_CMP_SIGNED_EN
  logic       signed_mode;
`endif
  logic       busy;
  logic       done;
  logic [1:0] sout;

`ifdef SERIAL_CMP_SIGNED_EN
  modport master (output start, bit_vld, ai, bi, signed_mode,
                  input  busy, done, sout);
  modport slave  (input  start, bit_vld, ai, bi, signed_mode,
                  output busy, done, sout);
`else
  modport master (output start, bit_vld, ai, bi,
                  input  busy, done, sout);
  modport slave  (input  start, bit_vld, ai, bi,
                  output busy, done, sout);
`endif
endinterface

// File: rtl/serial_comparator_cell.sv
// serial_cmp_cell: combinational per-bit decision update.
//   comp_i/decided_i : running result and "MSB-first result locked" flag
//   ai_i/bi_i        : current bit pair
//   msb_first_i      : bit order (1 = MSB first)
//   is_sign_i        : current pair is the sign position   (SERIAL_CMP_SIGNED_EN)
//   signed_i         : two's-complement compare selected   (SERIAL_CMP_SIGNED_EN)
//   comp_o/decided_o : updated result and lock flag
// Optional macro: SERIAL_CMP_SIGNED_EN adds the sign-position inversion.
module serial_cmp_cell
  import serial_cmp_pkg::*;
(
`ifdef SERIAL_CMP_SIGNED_EN
  input  logic       is_sign_i,
  input  logic       signed_i,
`endif
  input  logic [1:0] comp_i,
  input  logic       decided_i,
  input  logic       ai_i,
  input  logic       bi_i,
  input  logic       msb_first_i,
  output logic [1:0] comp_o,
  output logic       decided_o
);

  logic       diff;
  logic       inv;
  logic [1:0] code;

  always_comb begin
    diff = ai_i ^ bi_i;
`ifdef SERIAL_CMP_SIGNED_EN
    inv  = signed_i & is_sign_i;
`else
    inv  = 1'b0;
`endif
    code      = pair_code(ai_i, bi_i, inv);
    comp_o    = comp_i;
    decided_o = decided_i;
    if (diff) begin
      if (!msb_first_i) begin
        // LSB first: the most significant difference arrives last and wins.
        comp_o = code;
      end else if (!decided_i) begin
        // MSB first: the first difference settles the result.
        comp_o    = code;
        decided_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/serial_comparator.sv
// serial_comparator: bit-serial magnitude comparator of two WIDTH-bit operands.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : serial_cmp_if.slave
//     start       begin a compare (sampled in IDLE only)
//     bit_vld     ai/bi hold a valid pair (sampled in OP only)
//     ai, bi      serial operand bits
//     signed_mode two's-complement compare, latched at start (SERIAL_CMP_SIGNED_EN)
//     busy        high in OP and DONE
//     done        one-cycle result strobe
//     sout        result code (00 NA, 01 LT, 10 EQ, 11 GT), registered
// Parameters: WIDTH (2..256), MSB_FIRST (0 = LSB first).
// Optional macro: SERIAL_CMP_SIGNED_EN enables signed compare.
module serial_comparator
  import serial_cmp_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  serial_cmp_if.slave  bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [1:0]         comp_q, comp_d;
  logic               decided_q, decided_d;
  logic [1:0]         sout_q, sout_d;
`ifdef SERIAL_CMP_SIGNED_EN
  logic               signed_q, signed_d;
`endif

  logic               last_bit;
  logic               is_sign;
  logic [1:0]         cell_comp;
  logic               cell_decided;

  assign last_bit = bus.bit_vld && (count_q == CNT_W'(WIDTH - 1));
  assign is_sign  = MSB_FIRST ? (count_q == '0) : (count_q == CNT_W'(WIDTH - 1));

  serial_cmp_cell u_cell (
`ifdef SERIAL_CMP_SIGNED_EN
    .is_sign_i   (is_sign),
    .signed_i    (signed_q),
`endif
    .comp_i      (comp_q),
    .decided_i   (decided_q),
    .ai_i        (bus.ai),
    .bi_i        (bus.bi),
    .msb_first_i (MSB_FIRST),
    .comp_o      (cell_comp),
    .decided_o   (cell_decided)
  );

`ifndef SERIAL_CMP_SIGNED_EN
  // Sign position only matters for the signed build.
  logic unused_sign;
  assign unused_sign = is_sign;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (bus.start) state_d = ST_OP;
      ST_OP:   if (last_bit)  state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath / output next values
  always_comb begin
    count_d   = count_q;
    comp_d    = comp_q;
    decided_d = decided_q;
    sout_d    = sout_q;
`ifdef SERIAL_CMP_SIGNED_EN
    signed_d  = signed_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          count_d   = '0;
          comp_d    = CMP_EQ;
          decided_d = 1'b0;
          sout_d    = CMP_NA;
`ifdef SERIAL_CMP_SIGNED_EN
          signed_d  = bus.signed_mode;
`endif
        end
      end
      ST_OP: begin
        if (bus.bit_vld) begin
          count_d   = count_q + CNT_W'(1);
          comp_d    = cell_comp;
          decided_d = cell_decided;
          // Load sout with the final result so it is valid during DONE.
          if (last_bit) sout_d = cell_comp;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q   <= '0;
      comp_q    <= CMP_NA;
      decided_q <= 1'b0;
      sout_q    <= CMP_NA;
`ifdef SERIAL_CMP_SIGNED_EN
      signed_q  <= 1'b0;
`endif
    end else begin
      count_q   <= count_d;
      comp_q    <= comp_d;
      decided_q <= decided_d;
      sout_q    <= sout_d;
`ifdef SERIAL_CMP_SIGNED_EN
      signed_q  <= signed_d;
`endif
    end
  end

  assign bus.busy = (state_q != ST_IDLE);
  assign bus.done = (state_q == ST_DONE);
  assign bus.sout = sout_q;

endmodule

// File: tb/tb_serial_comparator.sv
// Bench for serial_comparator: three instances (W8 LSB-first, W8 MSB-first,
// W16 MSB-first), directed cases plus random operands/gaps checked against an
// arithmetic compare of the whole operands.
module tb_serial_comparator;
  import serial_cmp_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  serial_cmp_if if0 ();
  serial_cmp_if if1 ();
  serial_cmp_if if2 ();

  logic [2:0] start_v = '0, vld_v = '0, ai_v = '0, bi_v = '0;
  logic [2:0] busy_v, done_v;
  logic [1:0] sout_v [3];

  assign if0.start = start_v[0]; assign if0.bit_vld = vld_v[0];
  assign if0.ai    = ai_v[0];    assign if0.bi      = bi_v[0];
  assign if1.start = start_v[1]; assign if1.bit_vld = vld_v[1];
  assign if1.ai    = ai_v[1];    assign if1.bi      = bi_v[1];
  assign if2.start = start_v[2]; assign if2.bit_vld = vld_v[2];
  assign if2.ai    = ai_v[2];    assign if2.bi      = bi_v[2];
  assign busy_v = {if2.busy, if1.busy, if0.busy};
  assign done_v = {if2.done, if1.done, if0.done};
  assign sout_v[0] = if0.sout;
  assign sout_v[1] = if1.sout;
  assign sout_v[2] = if2.sout;

`ifdef SERIAL_CMP_SIGNED_EN
  logic [2:0] sgn_v = '0;
  assign if0.signed_mode = sgn_v[0];
  assign if1.signed_mode = sgn_v[1];
  assign if2.signed_mode = sgn_v[2];
`endif

  serial_comparator #(.WIDTH(8),  .MSB_FIRST(1'b0)) u_d0 (.clk(clk), .rst(rst), .bus(if0));
  serial_comparator #(.WIDTH(8),  .MSB_FIRST(1'b1)) u_d1 (.clk(clk), .rst(rst), .bus(if1));
  serial_comparator #(.WIDTH(16), .MSB_FIRST(1'b1)) u_d2 (.clk(clk), .rst(rst), .bus(if2));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: compare the whole operands as numbers.
  function automatic logic [1:0] ref_cmp(input int w, input logic [15:0] a,
                                         input logic [15:0] b, input bit sgn);
    int va, vb;
    va = int'(a) & ((1 << w) - 1);
    vb = int'(b) & ((1 << w) - 1);
    if (sgn && ((va >> (w - 1)) & 1) != 0) va = va - (1 << w);
    if (sgn && ((vb >> (w - 1)) & 1) != 0) vb = vb - (1 << w);
    if (va < vb)  return CMP_LT;
    if (va == vb) return CMP_EQ;
    return CMP_GT;
  endfunction

  function automatic int dut_w(input int d);
    return (d == 2) ? 16 : 8;
  endfunction

  // One full compare on instance d with ngaps idle cycles spread among the bits.
  task automatic run_cmp(input int d, input logic [15:0] a, input logic [15:0] b,
                         input bit sgn, input int ngaps, input bit poke);
    int         w, s, gl, t, idx;
    logic [1:0] exp;
    w   = dut_w(d);
    exp = ref_cmp(w, a, b, sgn);
    @(negedge clk);
    start_v[d] = 1'b1;
    vld_v[d]   = 1'b1;                 // must be ignored in the start cycle
    ai_v[d]    = 1'($urandom);
    bi_v[d]    = 1'($urandom);
`ifdef SERIAL_CMP_SIGNED_EN
    sgn_v[d]   = sgn;
`endif
    s  = cyc;
    gl = ngaps;
    for (int i = 0; i < w; i++) begin
      while (gl > 0 && (i == w - 1 || $urandom_range(0, 1) == 1)) begin
        @(negedge clk);
        start_v[d] = poke;
        vld_v[d]   = 1'b0;
        ai_v[d]    = 1'($urandom);
        bi_v[d]    = 1'($urandom);
        gl--;
      end
      @(negedge clk);
      check("op_state", {28'd0, busy_v[d], done_v[d], sout_v[d]}, 32'b1000);
      idx        = (d == 0) ? i : (w - 1 - i);
      start_v[d] = poke && (i == w / 2);
      vld_v[d]   = 1'b1;
      ai_v[d]    = a[idx];
      bi_v[d]    = b[idx];
    end
    @(negedge clk);
    start_v[d] = 1'b0;
    vld_v[d]   = 1'b0;
    t = 0;
    while (!done_v[d] && t < 40) begin
      @(negedge clk);
      t++;
    end
    check("done_seen", 32'(done_v[d]), 32'd1);
    check("latency",   32'(cyc - s),   32'(w + 1 + ngaps));
    check("sout",      32'(sout_v[d]), 32'(exp));
    check("busy_done", 32'(busy_v[d]), 32'd1);
    start_v[d] = poke;                 // start in DONE must be ignored
    @(negedge clk);
    start_v[d] = 1'b0;
    check("idle_after", {28'd0, busy_v[d], done_v[d], sout_v[d]}, {28'd0, 2'b00, exp});
  endtask

  initial begin
    logic [15:0] a, b;
    bit          sg;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++)
      check("reset_state", {28'd0, busy_v[d], done_v[d], sout_v[d]}, 32'd0);
    rst = 1'b0;

    run_cmp(0, 16'h5A, 16'h5A, 1'b0, 0, 1'b0);       // equal, 9-cycle latency
    run_cmp(0, 16'h80, 16'h7F, 1'b0, 0, 1'b0);       // unsigned GT
`ifdef SERIAL_CMP_SIGNED_EN
    run_cmp(0, 16'h80, 16'h7F, 1'b1, 0, 1'b0);       // signed LT, LSB first
    run_cmp(1, 16'h80, 16'h7F, 1'b1, 0, 1'b0);       // signed LT, MSB first
    run_cmp(1, 16'h05, 16'hFE, 1'b1, 1, 1'b0);       // 5 > -2
`endif
    run_cmp(2, 16'h1234, 16'h1235, 1'b0, 5, 1'b0);   // LT with gaps
    run_cmp(1, 16'h40, 16'h3F, 1'b0, 0, 1'b0);       // decided early, GT
    run_cmp(0, 16'h33, 16'h35, 1'b0, 2, 1'b1);       // start pokes ignored

    // Async reset after the 4th bit: outputs clear at once, no done follows.
    @(negedge clk);
    start_v[0] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      start_v[0] = 1'b0;
      vld_v[0]   = 1'b1;
      ai_v[0]    = 1'b1;
      bi_v[0]    = 1'b0;
    end
    @(negedge clk);
    vld_v[0] = 1'b0;
    check("pre_rst_busy", 32'(busy_v[0]), 32'd1);
    #2 rst = 1'b1;
    #1 check("rst_async", {28'd0, busy_v[0], done_v[0], sout_v[0]}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    vld_v[0] = 1'b1;
    repeat (12) begin
      @(negedge clk);
      check("no_done_after_rst", {30'd0, busy_v[0], done_v[0]}, 32'd0);
    end
    vld_v[0] = 1'b0;
    run_cmp(0, 16'h03, 16'h03, 1'b0, 0, 1'b0);

    // Random operands, gaps and (when built in) signed mode.
    for (int k = 0; k < 45; k++) begin
      int d;
      d = k % 3;
      a = 16'($urandom);
      case ($urandom_range(0, 2))
        0:       b = a;
        1:       b = a ^ (16'd1 << $urandom_range(0, dut_w(d) - 1));
        default: b = 16'($urandom);
      endcase
      sg = 1'b0;
`ifdef SERIAL_CMP_SIGNED_EN
      sg = 1'($urandom);
`endif
      run_cmp(d, a, b, sg, $urandom_range(0, 3), 1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_comparator.md
Name: serial_comparator

Overview:
- Bit-serial magnitude comparator for two WIDTH-bit operands, presented one bit pair per accepted cycle.
- Successor to the fixed 8-bit serial comparator. Adds:
  - parametrised width;
  - selectable bit order (LSB- or MSB-first);
  - a per-bit valid qualifier, so gaps are allowed;
  - an explicit busy/done handshake;
  - optional two's-complement comparison.
- Sits between serial operand sources (shift-out ports) and control logic that consumes a 2-bit compare code.

Parameters:
- WIDTH, 8, operand width in bits; legal range 2..256.
- MSB_FIRST, 0, bit order: 0 = LSB first, 1 = MSB first.
- CNT_W, $clog2(WIDTH+1), derived localparam; bit counter width. Not overridable.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  begin a comparison; sampled only in IDLE
- bit_vld  in  1  ai/bi carry a valid bit pair this cycle; sampled only in OP
- ai  in  1  serial bit of operand A
- bi  in  1  serial bit of operand B
- signed_mode  in  1  present only with SERIAL_CMP_SIGNED_EN; 1 = two's-complement compare; sampled on accepted start
- busy  out  1  high in OP and DONE
- done  out  1  one-cycle pulse: result valid
- sout  out  2  result code: 00 NA, 01 A<B, 10 A==B, 11 A>B

Behaviour:
- Reset (async, active-high):
  - state = IDLE, count = 0, comp = 00, sout = 00, done = 0, busy = 0.
  - Reset mid-operation aborts the compare. No done pulse; sout reads 00.
- FSM states IDLE, OP, DONE; all outputs are decoded from registers, with no combinational path from inputs to outputs.
- IDLE:
  - start = 1 -> OP; count = 0; comp = 10 (equal); decided = 0.
  - Operand bits are accepted from the next cycle onward. ai/bi/bit_vld in the start cycle are ignored.
- OP:
  - Each cycle with bit_vld = 1 consumes one bit pair and increments count. Cycles with bit_vld = 0 hold all state.
  - LSB-first: every differing pair overwrites comp (ai>bi -> 11, ai<bi -> 01). Equal pairs hold comp.
  - MSB-first: the first differing pair sets comp and sets decided. Later pairs are consumed but do not change comp.
  - When the WIDTH-th pair is accepted (count == WIDTH-1 and bit_vld), the next state is DONE.
  - start is ignored in OP and DONE. There is no queuing.
- DONE (exactly one cycle):
  - done = 1; sout = comp; next state IDLE.
  - Latency: done rises on the cycle after the edge that sampled the last bit. With no gaps, start-to-done = WIDTH+1 cycles.
- sout behaviour:
  - Registered.
  - Reads 00 throughout OP.
  - Takes the result in DONE and holds it through IDLE until the next accepted start (after which it reads 00 again).
- busy = (state != IDLE).
- start asserted in the DONE cycle is ignored. Back-to-back operation needs start in the first IDLE cycle, giving a minimum spacing of WIDTH+2 cycles.

Optional Feature:
- Macro: SERIAL_CMP_SIGNED_EN.
- Defined:
  - signed_mode port exists and is latched at start.
  - With signed_mode = 1, the sign-bit pair is handled with inverted sense (ai=1, bi=0 -> 01; ai=0, bi=1 -> 11).
  - MSB-first: the sign pair is the first pair. If it differs, it decides the result.
  - LSB-first: the sign pair is the last pair. If it differs, it overrides comp with inverted sense.
  - If the sign bits are equal, the result is the unsigned result.
- Undefined: no signed_mode port; always unsigned; no sign-handling logic.

Decomposition:
- Package serial_cmp_pkg:
  - result-code localparams CMP_NA = 2'b00, CMP_LT = 2'b01, CMP_EQ = 2'b10, CMP_GT = 2'b11;
  - state typedef (IDLE/OP/DONE).
- One sub-module is natural: serial_cmp_cell.
  - Per-bit decision update, combinational: in comp, decided, ai, bi, msb_first, is_sign_bit, signed -> out next comp, next decided.
  - The top level keeps the FSM, counter and output registers.

Test Plan:
- WIDTH=8, LSB-first, A=0x5A, B=0x5A, no gaps -> done 9 cycles after start; sout = 10; busy falls with done.
- WIDTH=8, LSB-first, A=0x80, B=0x7F -> sout = 11. With SERIAL_CMP_SIGNED_EN and signed_mode=1 -> sout = 01.
- WIDTH=16, MSB_FIRST=1, A=0x1234, B=0x1235, bit_vld deasserted on 5 random cycles -> sout = 01; done exactly 17+5 cycles after start.
- MSB_FIRST=1, WIDTH=8, A=0x40, B=0x3F -> decided at the 2nd bit; sout = 11 despite later A<B bits.
- start re-pulsed mid-OP and in DONE -> ignored; exactly one done pulse; result unchanged.
- rst asserted asynchronously after the 4th bit -> outputs 00/0/0 immediately; no done. A fresh start with A=3, B=3 -> sout = 10.
